// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between instruction and data buses
//
// Purpose: lets one single-port synchronous RAM serve both the instruction
// fetch bus and the data bus. Data has priority. A starvation counter makes
// sure an instruction fetch is granted after at most STARVE_MAX back-to-back
// data grants. Read data is returned one cycle after the grant, to whichever
// bus owned that access.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_req/i_addr                    instruction read request
//   i_ready/i_rvalid/i_rdata        instruction accept, read response
//   d_req/d_wen/d_addr/d_wdata      data read/write request
//   d_ready/d_rvalid/d_rdata        data accept, read response
//   mem_en/mem_wen/mem_addr/
//   mem_wdata/mem_rdata             memory port (rdata valid one cycle after a read)

module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,

  input  logic              d_req,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,

  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    RESP_IDLE = 2'd0,
    RESP_I_RD = 2'd1,
    RESP_D_RD = 2'd2
  } resp_e;

  resp_e       resp_q, resp_d;
  logic [3:0]  starve_q, starve_d;
  logic        grant_i, grant_d;
  logic        starve_hit;

  // Grant decode. Both grants are gated by rst_n so nothing reaches the
  // memory while reset is held, even though reset is asynchronous.
  always_comb begin
    starve_hit = i_req && (starve_q == STARVE_LIM);
    grant_d    = rst_n && d_req && !starve_hit;
    grant_i    = rst_n && i_req && !grant_d;
  end

  assign i_ready = grant_i;
  assign d_ready = grant_d;

  // Memory port drive; idle port is held at all-zero.
  always_comb begin
    mem_en    = grant_i || grant_d;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_d) begin
      mem_wen   = d_wen;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (grant_i) begin
      mem_addr  = i_addr;
    end
  end

  // Response owner for the next cycle and starvation counter update.
  always_comb begin
    resp_d = RESP_IDLE;
    if (grant_i) begin
      resp_d = RESP_I_RD;
    end else if (grant_d && !d_wen) begin
      resp_d = RESP_D_RD;
    end

    starve_d = 4'd0;
    if (i_req && grant_d) begin
      starve_d = (starve_q == STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q   <= RESP_IDLE;
      starve_q <= 4'd0;
    end else begin
      resp_q   <= resp_d;
      starve_q <= starve_d;
    end
  end

  // Response side: valid comes straight from the registered owner, data is
  // steered from the memory and zeroed on the bus that does not own it.
  always_comb begin
    i_rvalid = (resp_q == RESP_I_RD);
    d_rvalid = (resp_q == RESP_D_RD);
    i_rdata  = i_rvalid ? mem_rdata : '0;
    d_rdata  = d_rvalid ? mem_rdata : '0;
  end

endmodule
